// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side and SRAM-side signals of the three-port SRAM arbiter.
// The arbiter uses the slave modport; whoever plays the requesters and the SRAM uses master.
interface sram_arbiter_if;
   logic [2:0]   m_stb;
   logic [2:0]   m_we;
   logic [59:0]  m_addr;
   logic [143:0] m_din;
   logic [47:0]  m_dout;
   logic [2:0]   m_ack;
   logic [2:0]   m_err;
   logic         sram_stb;
   logic [19:0]  sram_addr;
   logic [47:0]  sram_din;
   logic         sram_we;
   logic [47:0]  sram_dout;
   logic         sram_ack;
   logic [1:0]   grant;
   modport slave (
      input  m_stb, m_we, m_addr, m_din, sram_dout, sram_ack,
      output m_dout, m_ack, m_err, sram_stb, sram_addr, sram_din, sram_we, grant
   );
   modport master (
      output m_stb, m_we, m_addr, m_din, sram_dout, sram_ack,
      input  m_dout, m_ack, m_err, sram_stb, sram_addr, sram_din, sram_we, grant
   );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: three-requester SRAM arbiter (IDLE/BUSY/RESP) with registered outputs and a BUSY timeout.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module sram_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic          clk50,
   input  logic          rst,
   sram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  grant_q, grant_d, win;
   logic        stb_q, stb_d, we_q, we_d;
   logic [19:0] addr_q, addr_d;
   logic [47:0] din_q, din_d, dout_q, dout_d;
   logic [2:0]  ack_q, ack_d, err_q, err_d;
   logic        start, done, tmo;
   assign start = state_q == IDLE && |bus.m_stb;
   assign done  = state_q == BUSY && bus.sram_ack;
   // an ack on the timeout edge wins, so the timeout is qualified by !sram_ack
   assign tmo   = state_q == BUSY && !bus.sram_ack && cnt_q == 8'(TIMEOUT - 1);
`ifdef SRAM_ARB_RR_EN
   logic [1:0] last_q, last_d, c0, c1, c2;
   always_comb begin
      c0 = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
      c1 = c0 == 2'd2 ? 2'd0 : c0 + 2'd1;
      c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
      win = bus.m_stb[c0] ? c0 : bus.m_stb[c1] ? c1 : c2;
      last_d = start ? win : last_q;
   end
   always_ff @(posedge clk50 or posedge rst)
      if (rst) last_q <= 2'd2;
      else last_q <= last_d;
`else
   assign win = bus.m_stb[0] ? 2'd0 : bus.m_stb[1] ? 2'd1 : 2'd2;
`endif
   always_ff @(posedge clk50 or posedge rst)
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = start ? BUSY : (done || tmo) ? RESP : state_q == BUSY ? BUSY : IDLE;
   end
   always_comb begin
      grant_d = start ? win : state_q == RESP ? 2'd3 : grant_q;
      stb_d   = start || (state_q == BUSY && !done && !tmo);
      we_d    = start ? bus.m_we[win] : we_q;
      addr_d  = start ? bus.m_addr[win*20 +: 20] : addr_q;
      din_d   = start ? (bus.m_we[win] ? bus.m_din[win*48 +: 48] : 48'h0) : din_q;
      cnt_d   = state_q == BUSY && !done ? cnt_q + 8'd1 : 8'd0;
      ack_d   = done || tmo ? 3'b001 << grant_q : 3'b000;
      err_d   = tmo ? 3'b001 << grant_q : 3'b000;
      dout_d  = done ? bus.sram_dout : tmo ? 48'h0 : dout_q;
   end
   always_ff @(posedge clk50 or posedge rst)
      if (rst) begin
         grant_q <= 2'd3;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 20'h0;
         din_q   <= 48'h0;
         cnt_q   <= 8'd0;
         ack_q   <= 3'b000;
         err_q   <= 3'b000;
         dout_q  <= 48'h0;
      end else begin
         grant_q <= grant_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   assign bus.grant     = grant_q;
   assign bus.sram_stb  = stb_q;
   assign bus.sram_we   = we_q;
   assign bus.sram_addr = addr_q;
   assign bus.sram_din  = din_q;
   assign bus.m_ack     = ack_q;
   assign bus.m_err     = err_q;
   assign bus.m_dout    = dout_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized self-checking bench for sram_arbiter (TIMEOUT=4) against a transaction-level model.
// The bench plays all three requesters and the SRAM; expected grants come from the arbitration rule.
module tb_sram_arbiter;
   logic clk50 = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [1:0]  last_m = 2'd2;
   logic [19:0] ea [3];
   logic [47:0] ed [3];
   logic [2:0]  ew;
   int wn, sn;
   logic [1:0]  g, g2;
   logic [19:0] a;
   logic        w;
   logic [47:0] d, dout;
   bit          hold, got;
   logic [2:0]  ack, err, ack2;
   sram_arbiter_if bus();
   sram_arbiter #(.TIMEOUT(4)) dut (.clk50(clk50), .rst(rst), .bus(bus));
   always #5 clk50 = ~clk50;
   function automatic logic [1:0] pick(input logic [2:0] m, input logic [1:0] last);
`ifdef SRAM_ARB_RR_EN
      for (int k = 1; k <= 3; k++) begin
         int i = (int'(last) + k) % 3;
         if (m[i]) return 2'(i);
      end
`else
      for (int i = 0; i < 3; i++) if (m[i]) return 2'(i);
`endif
      return 2'd3;
   endfunction
   task automatic step();
      @(posedge clk50);
      #1;
   endtask
   task automatic raise(input int i);
      ea[i] = 20'($urandom);
      ed[i] = {16'($urandom), 32'($urandom)};
      ew[i] = 1'($urandom);
      bus.m_addr[i*20 +: 20] = ea[i];
      bus.m_din[i*48 +: 48] = ed[i];
      bus.m_we[i] = ew[i];
      bus.m_stb[i] = 1'b1;
   endtask
   // Acts as the SRAM: waits for a strobe, acks lat cycles after it (never if lat<0), records what it saw.
   task automatic serve(input int lat, input logic [47:0] rd, input bit drop);
      wn = 0; sn = 0; hold = 1; got = 0; ack = '0; err = '0; dout = '0;
      while (bus.sram_stb !== 1'b1 && wn < 20) begin step(); wn++; end
      g = bus.grant; a = bus.sram_addr; w = bus.sram_we; d = bus.sram_din;
      if (bus.sram_stb === 1'b1) begin
         sn = 1;
         for (int n = 0; n < 300 && !got; n++) begin
            bus.sram_ack = (n == lat);
            bus.sram_dout = (n == lat) ? rd : {16'($urandom), 32'($urandom)};
            step();
            if (bus.sram_stb === 1'b1) begin
               sn++;
               if ({bus.sram_addr, bus.sram_we, bus.sram_din, bus.grant} !== {a, w, d, g}) hold = 0;
            end
            if (bus.m_ack !== 3'b000) begin got = 1; ack = bus.m_ack; err = bus.m_err; dout = bus.m_dout; end
         end
      end
      bus.sram_ack = 1'b0;
      if (drop) bus.m_stb = bus.m_stb & ~ack;
      step();
      ack2 = bus.m_ack;
      g2 = bus.grant;
   endtask
   task automatic test_reset();
      bus.m_stb = '0; bus.m_we = '0; bus.m_addr = '0; bus.m_din = '0;
      bus.sram_ack = 1'b0; bus.sram_dout = '0;
      step(); step();
      checks++; if (bus.grant !== 2'd3) begin failures++; $display("FAIL reset_grant got=%0d exp=3", bus.grant); end
      checks++; if ({bus.sram_stb, bus.sram_we} !== 2'b00) begin failures++; $display("FAIL reset_stb_we got=%b exp=00", {bus.sram_stb, bus.sram_we}); end
      checks++; if ({bus.sram_addr, bus.sram_din} !== 68'h0) begin failures++; $display("FAIL reset_addr_din got=%h exp=0", {bus.sram_addr, bus.sram_din}); end
      checks++; if ({bus.m_ack, bus.m_err, bus.m_dout} !== 54'h0) begin failures++; $display("FAIL reset_m_outs got=%h exp=0", {bus.m_ack, bus.m_err, bus.m_dout}); end
      rst = 1'b0;
      last_m = 2'd2;
   endtask
   task automatic test_single_read();
      bus.m_addr = {40'($urandom), 20'h00010};
      bus.m_we = 3'b000;
      bus.m_stb = 3'b001;
      serve(2, 48'h0000_1234_5678, 1);
      checks++; if (wn !== 1) begin failures++; $display("FAIL read_first_grant_latency got=%0d exp=1", wn); end
      checks++; if (g !== 2'd0) begin failures++; $display("FAIL read_grant got=%0d exp=0", g); end
      checks++; if ({a, w, d} !== {20'h00010, 1'b0, 48'h0}) begin failures++; $display("FAIL read_sram_req got=%h/%b/%h exp=00010/0/0", a, w, d); end
      checks++; if (sn !== 3) begin failures++; $display("FAIL read_stb_cycles got=%0d exp=3", sn); end
      checks++; if ({got, ack, err} !== {1'b1, 3'b001, 3'b000}) begin failures++; $display("FAIL read_ack got=%b/%b/%b exp=1/001/000", got, ack, err); end
      checks++; if (dout !== 48'h0000_1234_5678) begin failures++; $display("FAIL read_dout got=%h exp=000012345678", dout); end
      checks++; if ({ack2, g2} !== {3'b000, 2'd3}) begin failures++; $display("FAIL read_ack_one_cycle got=%b/%0d exp=000/3", ack2, g2); end
      last_m = 2'd0;
   endtask
   task automatic test_write();
      bus.m_addr[59:40] = 20'hFFFFF;
      bus.m_din[143:96] = 48'hAAAA_5555_0F0F;
      bus.m_we = 3'b100;
      bus.m_stb = 3'b100;
      serve($urandom_range(1, 2), 48'h0, 1);
      checks++; if (g !== 2'd2) begin failures++; $display("FAIL write_grant got=%0d exp=2", g); end
      checks++; if ({a, w, d} !== {20'hFFFFF, 1'b1, 48'hAAAA_5555_0F0F}) begin failures++; $display("FAIL write_sram_req got=%h/%b/%h exp=fffff/1/aaaa55550f0f", a, w, d); end
      checks++; if (!hold) begin failures++; $display("FAIL write_hold got=changed exp=stable"); end
      checks++; if ({got, ack, err} !== {1'b1, 3'b100, 3'b000}) begin failures++; $display("FAIL write_ack got=%b/%b/%b exp=1/100/000", got, ack, err); end
      last_m = 2'd2;
   endtask
   task automatic test_drop_stb();
      raise(0);
      bus.m_we = 3'b000;
      step();
      bus.m_stb = 3'b000;
      serve(1, 48'h0BAD_CAFE_0001, 1);
      checks++; if ({got, ack, err} !== {1'b1, 3'b001, 3'b000}) begin failures++; $display("FAIL drop_stb_ack got=%b/%b/%b exp=1/001/000", got, ack, err); end
      checks++; if (dout !== 48'h0BAD_CAFE_0001) begin failures++; $display("FAIL drop_stb_dout got=%h exp=0badcafe0001", dout); end
      last_m = 2'd0;
   endtask
   task automatic test_timeout();
      raise(1);
      serve(-1, 48'h1111_2222_3333, 1);
      checks++; if (sn !== 4) begin failures++; $display("FAIL timeout_stb_cycles got=%0d exp=4", sn); end
      checks++; if ({got, ack, err} !== {1'b1, 3'b010, 3'b010}) begin failures++; $display("FAIL timeout_ack_err got=%b/%b/%b exp=1/010/010", got, ack, err); end
      checks++; if (dout !== 48'h0) begin failures++; $display("FAIL timeout_dout got=%h exp=0", dout); end
      checks++; if ({ack2, g2} !== {3'b000, 2'd3}) begin failures++; $display("FAIL timeout_clear got=%b/%0d exp=000/3", ack2, g2); end
      last_m = 2'd1;
   endtask
   task automatic test_ack_at_timeout();
      raise(2);
      serve(3, 48'h7777_8888_9999, 1);
      checks++; if ({got, ack, err} !== {1'b1, 3'b100, 3'b000}) begin failures++; $display("FAIL ack_at_timeout got=%b/%b/%b exp=1/100/000", got, ack, err); end
      checks++; if (dout !== 48'h7777_8888_9999) begin failures++; $display("FAIL ack_at_timeout_dout got=%h exp=777788889999", dout); end
      last_m = 2'd2;
   endtask
   task automatic test_contention();
      logic [1:0] exp_g [4];
`ifdef SRAM_ARB_RR_EN
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
      exp_g = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
      rst = 1'b1; step(); rst = 1'b0; last_m = 2'd2;
      for (int i = 0; i < 3; i++) raise(i);
      for (int t = 0; t < 4; t++) begin
         serve(0, 48'(t), 0);
         checks++; if (g !== exp_g[t]) begin failures++; $display("FAIL contention_grant%0d got=%0d exp=%0d", t, g, exp_g[t]); end
         checks++; if ({got, ack, a} !== {1'b1, 3'b001 << exp_g[t], ea[exp_g[t]]}) begin failures++; $display("FAIL contention_ack%0d got=%b/%b/%h exp=1/%b/%h", t, got, ack, a, 3'b001 << exp_g[t], ea[exp_g[t]]); end
         last_m = exp_g[t];
      end
      bus.m_stb = 3'b000;
      step();
   endtask
   task automatic test_reset_mid_busy();
      raise(2);
      step();
      checks++; if (bus.sram_stb !== 1'b1) begin failures++; $display("FAIL rst_busy_pre got=%b exp=1", bus.sram_stb); end
      rst = 1'b1;
      #1;
      checks++; if ({bus.sram_stb, bus.sram_we, bus.sram_addr, bus.sram_din} !== 70'h0) begin failures++; $display("FAIL rst_busy_sram got=%h exp=0", {bus.sram_stb, bus.sram_we, bus.sram_addr, bus.sram_din}); end
      checks++; if ({bus.m_ack, bus.m_err, bus.m_dout, bus.grant} !== {54'h0, 2'd3}) begin failures++; $display("FAIL rst_busy_m got=%h exp=3", {bus.m_ack, bus.m_err, bus.m_dout, bus.grant}); end
      bus.m_stb = 3'b000;
      step();
      rst = 1'b0;
      last_m = 2'd2;
      bus.sram_ack = 1'b1;
      bus.sram_dout = 48'hDEAD_BEEF_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({bus.m_ack, bus.sram_stb, bus.grant} !== {3'b000, 1'b0, 2'd3}) begin failures++; $display("FAIL rst_late_ack%0d got=%b/%b/%0d exp=000/0/3", i, bus.m_ack, bus.sram_stb, bus.grant); end
      end
      bus.sram_ack = 1'b0;
   endtask
   task automatic test_random();
      logic [1:0]  eg;
      logic [47:0] rd;
      int lat;
      bit t_o;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 3; i++) if (!bus.m_stb[i] && $urandom_range(0, 1) == 1) raise(i);
         if (bus.m_stb == 3'b000) raise(int'($urandom_range(0, 2)));
         eg = pick(bus.m_stb, last_m);
         lat = int'($urandom_range(0, 4)) - 1;
         t_o = lat < 0;
         rd = {16'($urandom), 32'($urandom)};
         serve(lat, rd, 1);
         checks++; if (g !== eg) begin failures++; $display("FAIL rand%0d_grant got=%0d exp=%0d", t, g, eg); end
         checks++; if ({a, w, d} !== {ea[eg], ew[eg], ew[eg] ? ed[eg] : 48'h0}) begin failures++; $display("FAIL rand%0d_req got=%h/%b/%h exp=%h/%b/%h", t, a, w, d, ea[eg], ew[eg], ew[eg] ? ed[eg] : 48'h0); end
         checks++; if (!hold || sn !== (t_o ? 4 : lat + 1)) begin failures++; $display("FAIL rand%0d_busy got=hold%0d/%0d exp=hold1/%0d", t, hold, sn, t_o ? 4 : lat + 1); end
         checks++; if ({got, ack, err} !== {1'b1, 3'b001 << eg, t_o ? 3'b001 << eg : 3'b000}) begin failures++; $display("FAIL rand%0d_ack got=%b/%b/%b exp=1/%b/%b", t, got, ack, err, 3'b001 << eg, t_o ? 3'b001 << eg : 3'b000); end
         checks++; if (dout !== (t_o ? 48'h0 : rd)) begin failures++; $display("FAIL rand%0d_dout got=%h exp=%h", t, dout, t_o ? 48'h0 : rd); end
         checks++; if ({ack2, g2} !== {3'b000, 2'd3}) begin failures++; $display("FAIL rand%0d_resp got=%b/%0d exp=000/3", t, ack2, g2); end
         last_m = eg;
      end
   endtask
   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_drop_stb();
      test_timeout();
      test_ack_at_timeout();
      test_contention();
      test_reset_mid_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
